// File: rtl/tx_backoff_ctrl.sv
`timescale 1ns/1ps
// Transmit access controller: gates tx_sm starts behind carrier deferral and the
// inter-frame gap, and runs truncated binary exponential backoff after collisions.
module tx_backoff_ctrl #(
    parameter int          SLOT_TIME     = 64,
    parameter int          IFG_CYCLES    = 12,
    parameter int          MAX_ATTEMPTS  = 16,
    parameter int          BACKOFF_LIMIT = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       fifo_data_available,
    input  logic       carrier_sense,
    input  logic       collision,
    input  logic       tx_done,
    output logic       tx_start,
    output logic       fifo_retry,
    output logic       fifo_drop,
    output logic       late_collision,
    output logic [4:0] attempt_count
);
    // state    | meaning
    // IDLE     | no frame in flight
    // DEFER    | frame queued, waiting for a clear medium
    // IFG      | counting the inter-frame gap on a clear medium
    // START    | tx_start pulse, tx_sm launches the frame
    // TRANSMIT | frame on the wire, collision window open for one slot
    // WAIT_END | collided, waiting for tx_sm to finish the jam
    // BACKOFF  | waiting r slots before deferring again

    localparam int          GAP_W     = $clog2(IFG_CYCLES + 1);
    localparam int          WIN_W     = $clog2(SLOT_TIME + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(SLOT_TIME);
    localparam logic [WIN_W-1:0] INS_LOAD = WIN_W'(SLOT_TIME - 1);
    localparam logic [4:0]  K_MAX     = (BACKOFF_LIMIT > 10) ? 5'd10 : 5'(BACKOFF_LIMIT);
    localparam logic [4:0]  MAX_CNT   = 5'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE, S_DEFER, S_IFG, S_START, S_TRANSMIT, S_WAIT_END, S_BACKOFF
    } state_t;

    state_t           state, state_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [WIN_W-1:0] win_cnt, win_nxt;
    logic [WIN_W-1:0] ins_cnt, ins_nxt;
    logic [9:0]       slot_cnt, slot_nxt;
    logic [15:0]      lfsr;
    logic [4:0]       cnt_nxt;
    logic             late_pend, late_nxt;
    logic             done_pend, done_nxt;
    logic             start_nxt, retry_nxt, drop_nxt, latec_nxt;
    logic             medium_busy, coll_hd;
    logic [4:0]       bo_k;
    logic [9:0]       bo_mask;

    assign medium_busy = ~mode & carrier_sense;
    assign coll_hd     = ~mode & collision;

    always_comb begin
        bo_k    = (attempt_count > K_MAX) ? K_MAX : attempt_count;
        bo_mask = 10'((11'd1 << bo_k) - 11'd1);
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        win_nxt   = win_cnt;
        ins_nxt   = ins_cnt;
        slot_nxt  = slot_cnt;
        cnt_nxt   = attempt_count;
        late_nxt  = late_pend;
        done_nxt  = done_pend;
        start_nxt = 1'b0;
        retry_nxt = 1'b0;
        drop_nxt  = 1'b0;
        latec_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_data_available) state_nxt = S_DEFER;
            end
            S_DEFER: begin
                if (!medium_busy) begin
                    state_nxt = S_IFG;
                    gap_nxt   = GAP_LOAD;
                end
            end
            S_IFG: begin
                if (medium_busy) begin
                    state_nxt = S_DEFER;
                end else if (gap_cnt == '0) begin
                    state_nxt = S_START;
                    start_nxt = 1'b1;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            S_START: begin
                state_nxt = S_TRANSMIT;
                win_nxt   = WIN_LOAD;
            end
            S_TRANSMIT: begin
                // a tx_done coinciding with the collision still ends the jam wait
                if (coll_hd) begin
                    state_nxt = S_WAIT_END;
                    done_nxt  = tx_done;
                    if (win_cnt != '0) begin
                        cnt_nxt  = attempt_count + 5'd1;
                        late_nxt = 1'b0;
                    end else begin
                        cnt_nxt   = 5'd0;
                        late_nxt  = 1'b1;
                        latec_nxt = 1'b1;
                    end
                end else if (tx_done) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 5'd0;
                end else if (win_cnt != '0) begin
                    win_nxt = win_cnt - WIN_W'(1);
                end
            end
            S_WAIT_END: begin
                if (tx_done || done_pend) begin
                    done_nxt = 1'b0;
                    if (late_pend) begin
                        state_nxt = S_IDLE;
                        late_nxt  = 1'b0;
                    end else if (attempt_count == MAX_CNT) begin
                        state_nxt = S_IDLE;
                        drop_nxt  = 1'b1;
                        cnt_nxt   = 5'd0;
                    end else begin
                        state_nxt = S_BACKOFF;
                        retry_nxt = 1'b1;
                        slot_nxt  = lfsr[9:0] & bo_mask;
                        ins_nxt   = INS_LOAD;
                    end
                end
            end
            S_BACKOFF: begin
                if (slot_cnt == 10'd0) begin
                    state_nxt = S_DEFER;
                end else if (ins_cnt == '0) begin
                    slot_nxt = slot_cnt - 10'd1;
                    ins_nxt  = INS_LOAD;
                end else begin
                    ins_nxt = ins_cnt - WIN_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            gap_cnt        <= '0;
            win_cnt        <= '0;
            ins_cnt        <= '0;
            slot_cnt       <= 10'd0;
            lfsr           <= LFSR_SEED;
            attempt_count  <= 5'd0;
            late_pend      <= 1'b0;
            done_pend      <= 1'b0;
            tx_start       <= 1'b0;
            fifo_retry     <= 1'b0;
            fifo_drop      <= 1'b0;
            late_collision <= 1'b0;
        end else begin
            state          <= state_nxt;
            gap_cnt        <= gap_nxt;
            win_cnt        <= win_nxt;
            ins_cnt        <= ins_nxt;
            slot_cnt       <= slot_nxt;
            lfsr           <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            attempt_count  <= cnt_nxt;
            late_pend      <= late_nxt;
            done_pend      <= done_nxt;
            tx_start       <= start_nxt;
            fifo_retry     <= retry_nxt;
            fifo_drop      <= drop_nxt;
            late_collision <= latec_nxt;
        end
    end
endmodule

// File: tb/tb_tx_backoff_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for tx_backoff_ctrl: expected pulses are derived from the
// access rules as cycle numbers and checked by an independent monitor.
module tb_tx_backoff_ctrl;
    localparam int          SLOT = 8;
    localparam int          IFG  = 3;
    localparam int          MAXA = 16;
    localparam int          KLIM = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam logic [3:0] K_START = 4'b0001;
    localparam logic [3:0] K_RETRY = 4'b0010;
    localparam logic [3:0] K_DROP  = 4'b0100;
    localparam logic [3:0] K_LATE  = 4'b1000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b1;
    logic       fifo_data_available = 1'b0;
    logic       carrier_sense = 1'b0;
    logic       collision = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start, fifo_retry, fifo_drop, late_collision;
    logic [4:0] attempt_count;

    tx_backoff_ctrl #(
        .SLOT_TIME(SLOT), .IFG_CYCLES(IFG), .MAX_ATTEMPTS(MAXA),
        .BACKOFF_LIMIT(KLIM), .LFSR_SEED(SEED)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .fifo_data_available(fifo_data_available), .carrier_sense(carrier_sense),
        .collision(collision), .tx_done(tx_done), .tx_start(tx_start),
        .fifo_retry(fifo_retry), .fifo_drop(fifo_drop),
        .late_collision(late_collision), .attempt_count(attempt_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] kind;
        int         cycle;
        int         cnt;
    } exp_t;

    exp_t       sbq[$];
    bit         car_pat[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         attempts = 0;
    int         s_cyc = 0;
    logic [15:0] m_lfsr;
    logic [3:0] mon_obs;
    exp_t       mon_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            mon_obs = {late_collision, fifo_drop, fifo_retry, tx_start};
            if (mon_obs != 4'b0000) begin
                if (sbq.size() == 0) begin
                    check("unexpected_pulse", int'(mon_obs), 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("pulse_kind", int'(mon_obs), int'(mon_e.kind));
                    check("pulse_cycle", cyc, mon_e.cycle);
                    check("pulse_count", int'(attempt_count), mon_e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit car_at(input int i);
        return (i < car_pat.size()) ? car_pat[i] : 1'b0;
    endfunction

    // Start lands IFG+1 cycles after the first run of IFG+1 clear cycles that
    // begins no earlier than the cycle after the frame is seen.
    task automatic begin_frame(input bit md);
        int  c, t, s, bound;
        bit  clear, seen;
        mode = md;
        c = cyc;
        fifo_data_available = 1'b1;
        carrier_sense = car_at(0);
        t = c + 1;
        if (!md) begin
            for (int g = 0; g < 1000; g++) begin
                clear = 1'b1;
                for (int j = 0; j <= IFG; j++) if (car_at(t - c + j)) clear = 1'b0;
                if (clear) break;
                t++;
            end
        end
        s = t + IFG + 1;
        sbq.push_back('{K_START, s, attempts});
        bound = s - c + 20;
        seen = 1'b0;
        for (int i = 1; i < bound; i++) begin
            tick();
            carrier_sense = car_at(i);
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("start_timeout", 0, 1);
        fifo_data_available = 1'b0;
        carrier_sense = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_start(input int exp_cyc);
        int  bound;
        bit  seen;
        bound = exp_cyc - cyc + 20;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("backoff_start_timeout", 0, 1);
        s_cyc = cyc;
    endtask

    task automatic xmit_ok(input int len, input bit fd_coll);
        collision = fd_coll;
        repeat (len) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        collision = 1'b0;
        attempts = 0;
        check("count_after_done", int'(attempt_count), 0);
    endtask

    task automatic collide(input int w, input bit same_done, input int extra, output int exp_next);
        int x, d, k, r;
        logic [15:0] lf;
        exp_next = -1;
        repeat (w + 1) tick();
        collision = 1'b1;
        tx_done = same_done;
        x = cyc;
        tick();
        collision = 1'b0;
        tx_done = 1'b0;
        if (w < SLOT) begin
            attempts++;
            check("count_after_coll", int'(attempt_count), attempts);
            if (!same_done) begin
                repeat (extra) tick();
                tx_done = 1'b1;
            end
            d = cyc;
            lf = m_lfsr;
            if (attempts == MAXA) begin
                sbq.push_back('{K_DROP, d + 1, 0});
                attempts = 0;
            end else begin
                k = (attempts > KLIM) ? KLIM : attempts;
                r = int'(lf[9:0]) & ((1 << k) - 1);
                exp_next = d + 1 + r * SLOT + IFG + 2;
                sbq.push_back('{K_RETRY, d + 1, attempts});
                sbq.push_back('{K_START, exp_next, attempts});
            end
            tick();
            tx_done = 1'b0;
        end else begin
            sbq.push_back('{K_LATE, x + 1, 0});
            attempts = 0;
            repeat (extra) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("count_after_late", int'(attempt_count), 0);
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b0;
        sbq.delete();
        #1;
        check(name, int'({tx_start, fifo_retry, fifo_drop, late_collision, attempt_count}), 0);
        attempts = 0;
        collision = 1'b0;
        tx_done = 1'b0;
        fifo_data_available = 1'b0;
        carrier_sense = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nx;
        @(posedge clock);
        #1;
        check("reset_outputs", int'({tx_start, fifo_retry, fifo_drop, late_collision, attempt_count}), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        tick();

        // full duplex, carrier held, collision ignored
        car_pat.delete();
        repeat (30) car_pat.push_back(1'b1);
        begin_frame(1'b1);
        xmit_ok(5, 1'b1);

        // half duplex: 20 busy cycles, then a carrier blip inside the gap
        car_pat.delete();
        repeat (20) car_pat.push_back(1'b1);
        car_pat.push_back(1'b0);
        car_pat.push_back(1'b0);
        car_pat.push_back(1'b1);
        begin_frame(1'b0);
        xmit_ok(4, 1'b0);

        for (int n = 0; n < 4; n++) begin
            car_pat.delete();
            for (int i = 0; i < 30; i++) car_pat.push_back($urandom_range(2, 0) == 0);
            begin_frame(1'b0);
            xmit_ok($urandom_range(12, 1), 1'b0);
        end
        car_pat.delete();

        // single early collision at window cycle 2
        begin_frame(1'b0);
        collide(2, 1'b0, 2, nx);
        wait_start(nx);
        xmit_ok(6, 1'b0);

        // collision and tx_done in the same cycle
        begin_frame(1'b0);
        collide($urandom_range(SLOT - 1, 0), 1'b1, 0, nx);
        wait_start(nx);
        xmit_ok(3, 1'b0);

        // late collision exactly at SLOT_TIME, then idle
        begin_frame(1'b0);
        collide(SLOT, 1'b0, 1, nx);
        begin_frame(1'b1);
        xmit_ok(2, 1'b0);

        // excessive collisions: 15 retries then a drop
        begin_frame(1'b0);
        for (int n = 1; n <= MAXA; n++) begin
            collide($urandom_range(SLOT - 1, 0), 1'($urandom_range(1, 0)),
                    $urandom_range(3, 0), nx);
            if (n < MAXA) wait_start(nx);
        end
        tick();
        check("count_after_drop", int'(attempt_count), 0);
        begin_frame(1'b1);
        xmit_ok(3, 1'b0);

        // reset inside backoff, then clean restart
        begin_frame(1'b0);
        collide(1, 1'b0, 0, nx);
        do_reset("reset_mid_backoff");
        begin_frame(1'b1);
        xmit_ok(5, 1'b0);
        begin_frame(1'b0);
        collide(3, 1'b0, 1, nx);
        wait_start(nx);
        xmit_ok(4, 1'b0);

        // reset inside a retried transmission
        begin_frame(1'b0);
        collide(2, 1'b0, 0, nx);
        wait_start(nx);
        repeat (2) tick();
        do_reset("reset_mid_transmit");
        begin_frame(1'b1);
        xmit_ok(5, 1'b0);

        repeat (5) tick();
        check("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_backoff_ctrl.md
# tx_backoff_ctrl

Transmit access controller that sequences `tx_sm`: decides when a queued frame may start, enforces inter-frame gap and carrier deferral, and runs CSMA/CD truncated binary exponential backoff in half duplex. It sits between the transmit FIFO status and `tx_sm`. On collision it rewinds the FIFO with `fifo_retry`. After excessive collisions it discards the frame with `fifo_drop`.

## Interface
- `SLOT_TIME`, 64: clocks per backoff slot (512 bit times at byte clock)
- `IFG_CYCLES`, 12: clocks of idle medium required before each start
- `MAX_ATTEMPTS`, 16: attempts before drop (collision count reaching this value drops the frame)
- `BACKOFF_LIMIT`, 10: max backoff exponent k
- `LFSR_SEED`, 16'hACE1: nonzero LFSR reset value
- `clock` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-low reset
- `mode` in 1: 1 = full duplex, 0 = half duplex
- `fifo_data_available` in 1: complete frame queued
- `carrier_sense` in 1: medium busy (half duplex only)
- `collision` in 1: collision detected (half duplex only)
- `tx_done` in 1: one-cycle pulse from `tx_sm` at end of frame (incl. jam)
- `tx_start` out 1: one-cycle pulse, `tx_sm` begins frame
- `fifo_retry` out 1: one-cycle pulse, FIFO rewinds to frame start
- `fifo_drop` out 1: one-cycle pulse, FIFO discards current frame
- `late_collision` out 1: one-cycle pulse, collision after first slot
- `attempt_count` out 5: collisions suffered by current frame

## Operation
- States: IDLE, DEFER, IFG, START, TRANSMIT, WAIT_END, BACKOFF.
- IDLE: `fifo_data_available`=1 -> DEFER.
- DEFER: medium clear (`mode`=1 or `carrier_sense`=0) -> IFG, gap counter cleared.
- IFG: counts IFG_CYCLES cycles; half duplex `carrier_sense`=1 -> DEFER (gap restarts). Count complete -> START.
- START: `tx_start`=1 for this one cycle -> TRANSMIT; slot-window counter cleared.
- TRANSMIT: `tx_done` -> IDLE, `attempt_count` cleared. Half duplex `collision`=1:
  - window counter < SLOT_TIME: `attempt_count`+1 -> WAIT_END.
  - else: `late_collision` pulse, no retry, frame treated as done -> WAIT_END, count cleared.
- WAIT_END: wait `tx_done`. Normal collision: new count == MAX_ATTEMPTS -> `fifo_drop` pulse, count cleared, IDLE. Otherwise `fifo_retry` pulse -> BACKOFF. Late collision -> IDLE.
- BACKOFF: k = min(`attempt_count`, BACKOFF_LIMIT). r = LFSR[9:0] & ((1<<k)-1), sampled on entry. Waits r×SLOT_TIME cycles via slot counter (10 bit) and in-slot counter; r=0 -> DEFER next cycle. Then DEFER.
- `collision` and `carrier_sense` ignored in full duplex. `collision` ignored outside TRANSMIT.
- `collision` and `tx_done` in same TRANSMIT cycle: collision wins; the `tx_done` is consumed as WAIT_END's end.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock, never zero.
- `fifo_data_available` deasserting after IDLE is not re-checked; frame assumed present until done or dropped.

## Timing
- Reset (async assert, sync release) values: state IDLE, `tx_start`/`fifo_retry`/`fifo_drop`/`late_collision` 0, `attempt_count` 0, LFSR = LFSR_SEED, all counters 0.
- Reset mid-frame or mid-backoff aborts instantly. No pulse is emitted on reset.
- Start latency, clear medium: `fifo_data_available` sampled high at edge N -> DEFER at N+1 -> IFG N+2..N+IFG_CYCLES+1 -> `tx_start` high in cycle N+IFG_CYCLES+2.
- `fifo_retry`/`fifo_drop` asserted the cycle after `tx_done` sampled in WAIT_END.
- Backoff of r slots adds exactly r×SLOT_TIME cycles before DEFER.
- `attempt_count` updates the cycle after the collision is sampled.
- All outputs registered.

## Test plan
- Full duplex, SLOT_TIME=8, IFG_CYCLES=3, `carrier_sense`=1 held, frame available -> `tx_start` 5 cycles after sampling; `tx_done` -> IDLE, count 0.
- Half duplex, carrier high 20 cycles, dropping once during IFG -> gap restarts; `tx_start` exactly 3 idle cycles after last carrier drop.
- Half duplex collision at window cycle 2, then `tx_done` -> `attempt_count`=1, `fifo_retry` one pulse, backoff r∈{0,1} matching reference LFSR model (0 or 8 cycles), then DEFER/IFG/`tx_start`.
- 16 consecutive early collisions -> 15 `fifo_retry` pulses, then `fifo_drop` once, count 0, IDLE; backoff r never exceeds 1023 slots (k capped at 10).
- Collision at window cycle 8 (= SLOT_TIME) -> `late_collision` pulse, no `fifo_retry`, IDLE after `tx_done`.
- Assert `reset` low mid-BACKOFF and mid-TRANSMIT -> all outputs 0 immediately, LFSR = 16'hACE1; restart behaves as first test.
